fir_mac_engine: RTL and testbench

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_mac_engine_mult.sv | 40 ++++
 rtl/fir_mac_engine.sv | 131 +++++++++++++
 tb/tb_fir_mac_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR multiply-accumulate engine.
//   fir_state_e  : engine FSM states
//   N_DEFAULT    : default sample/coefficient width (signed Q(N/2).(N/2))
//   TAPS_DEFAULT : default filter length
//   Q_SAT_POS/NEG: saturation limits for the default 16-bit Q8.8 format
package fir_pkg;

  localparam int unsigned N_DEFAULT    = 16;
  localparam int unsigned TAPS_DEFAULT = 8;

  localparam logic [15:0] Q_SAT_POS = 16'h7FFF;
  localparam logic [15:0] Q_SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_mac_engine_mult.sv
// Multiplication: combinational signed Q(N/2).(N/2) multiplier.
//   a, b : signed Q operands (N bits)
//   p    : product, truncated by N/2 fractional LSBs and saturated to
//          +max (0x7FFF for N=16) or -max (0x8001) when it overflows N bits.
//          Exactly zero when either operand is zero.
module Multiplication #(
  parameter int unsigned N = 16
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p
);

  localparam int unsigned FRAC = N / 2;
  localparam logic [N-1:0] P_MAX = {1'b0, {(N-1){1'b1}}};
  // Negative overflow clamps symmetric to the positive limit, not to the
  // most negative code.
  localparam logic [N-1:0] P_MIN = {1'b1, {(N-2){1'b0}}, 1'b1};

  logic signed [2*N-1:0] full;
  logic signed [2*N-1:0] shifted;
  logic                  fits;

  always_comb begin
    full    = (2*N)'(a) * (2*N)'(b);
    shifted = full >>> FRAC;
    // Result fits in N bits when all bits above the N-bit sign agree with it.
    fits    = (&shifted[2*N-1:N-1]) | ~(|shifted[2*N-1:N-1]);
    if (a == '0 || b == '0) begin
      p = '0;
    end else if (fits) begin
      p = shifted[N-1:0];
    end else if (shifted[2*N-1]) begin
      p = P_MIN;
    end else begin
      p = P_MAX;
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: sequential single-multiplier FIR filter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : sample handshake (ready only when idle)
//   in_sample           : signed Q input sample
//   coef_we/addr/data   : coefficient write port, honoured only when idle
//   out_valid/out_ready : result handshake; result held until accepted
//   out_sample          : saturated filter output
//   busy                : engine is computing or holding a result
// One tap is multiplied and accumulated per cycle; the result is saturated
// to N bits when the last tap is added.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int unsigned N    = N_DEFAULT,
  parameter int unsigned TAPS = TAPS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_sample,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [N-1:0]            coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_sample,
  output logic                    busy
);

  localparam int unsigned IW = $clog2(TAPS);
  localparam int unsigned AW = N + IW + 1;
  localparam logic [N-1:0]  SAT_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  SAT_NEG  = {1'b1, {(N-1){1'b0}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  fir_state_e            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [AW-1:0]  acc_sum;
  logic                  sum_fits;
  logic signed [N-1:0]   x_q [TAPS];
  logic signed [N-1:0]   x_d [TAPS];
  logic signed [N-1:0]   h_q [TAPS];
  logic signed [N-1:0]   h_d [TAPS];
  logic [N-1:0]          out_q, out_d;
  logic signed [N-1:0]   prod;

  Multiplication #(.N(N)) u_mult (
    .a (x_q[idx_q]),
    .b (h_q[idx_q]),
    .p (prod)
  );

  always_comb begin
    acc_sum  = acc_q + AW'(prod);
    sum_fits = (&acc_sum[AW-1:N-1]) | ~(|acc_sum[AW-1:N-1]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    x_d     = x_q;
    h_d     = h_q;
    case (state_q)
      IDLE: begin
        // The write lands in h_q at the same edge as the transfer, so the
        // first MAC cycle already sees the new coefficient.
        if (coef_we) begin
          h_d[coef_addr] = coef_data;
        end
        if (in_valid) begin
          x_d[0] = in_sample;
          for (int unsigned k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          // Saturate the final sum (including this cycle's product) directly.
          idx_d   = '0;
          state_d = HOLD;
          out_d   = sum_fits ? acc_sum[N-1:0]
                             : (acc_sum[AW-1] ? SAT_NEG : SAT_POS);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        h_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      x_q     <= x_d;
      h_q     <= h_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == HOLD);
    busy       = (state_q != IDLE);
    out_sample = out_q;
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine (N=16, TAPS=8) with a behavioural
// reference model: an array of coefficients, a shifting sample history and an
// arithmetic Q8.8 dot product with saturation.
module tb_fir_mac_engine;

  localparam int N    = 16;
  localparam int TAPS = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_sample = '0;
  logic          coef_we = 1'b0;
  logic [2:0]    coef_addr = '0;
  logic [N-1:0]  coef_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_sample;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  int h_m [TAPS];
  int x_m [TAPS];

  always #5 clk = ~clk;

  fir_mac_engine #(.N(N), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_int(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Q8.8 product: floor of (a*b)/256, clamped to +/-32767 when out of range.
  function automatic int mul_ref(input int a, input int b);
    longint p;
    p = (longint'(a) * longint'(b)) >>> 8;
    if (p > 32767)  return 32767;
    if (p < -32768) return -32767;
    return int'(p);
  endfunction

  function automatic logic [15:0] filt_ref();
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += mul_ref(x_m[k], h_m[k]);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      h_m[k] = 0;
      x_m[k] = 0;
    end
  endtask

  task automatic model_push(input int x);
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_we = 1'b0;
    h_m[a] = to_int(d);
  endtask

  // Transfers one sample (optionally with a same-cycle coefficient write, and
  // optionally poking a write of h[0]=0x0200 while busy), waits for the result
  // and accepts it. lat counts edges including the transfer edge.
  task automatic run_sample(input logic [15:0] x, input logic wr, input logic [2:0] wa,
                            input logic [15:0] wd, input logic poke,
                            output logic [15:0] y, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_sample = x;
    coef_we = wr; coef_addr = wa; coef_data = wd;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    if (wr) h_m[wa] = to_int(wd);
    model_push(to_int(x));
    if (poke) begin coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h0200; end
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check("out_valid_wait", out_valid, 1);
    y = out_sample;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; coef_we = 1'b0;
    check("back_to_idle", in_ready, 1);
  endtask

  initial begin
    logic [15:0] y, yb, xa, xb, r;
    logic [15:0] imp_h [TAPS];
    int lat, n, cnt, t0, t1;

    imp_h = '{16'h0100, 16'h0080, 16'h0040, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sample", out_sample, 16'h0000);
    tick();
    rst_n = 1'b1;
    check("rel_in_ready", in_ready, 1);

    // Impulse response
    for (int k = 0; k < TAPS; k++) write_coef(3'(k), imp_h[k]);
    for (int j = 0; j < TAPS; j++) begin
      run_sample((j == 0) ? 16'h0100 : 16'h0000, 1'b0, 3'd0, 16'h0, 1'b0, y, lat);
      check($sformatf("impulse_%0d", j), y, imp_h[j]);
      if (j == 0) check("impulse_latency", lat, TAPS + 1);
    end

    // Positive saturation
    for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'h7F00);
    for (int j = 0; j < TAPS; j++) begin
      run_sample(16'h7F00, 1'b0, 3'd0, 16'h0, 1'b0, y, lat);
      check($sformatf("possat_model_%0d", j), y, filt_ref());
    end
    check("possat_final", y, 16'h7FFF);
    check("possat_latency", lat, TAPS + 1);

    // Negative saturation
    for (int j = 0; j < TAPS; j++) begin
      run_sample(16'h8100, 1'b0, 3'd0, 16'h0, 1'b0, y, lat);
      check($sformatf("negsat_model_%0d", j), y, filt_ref());
    end
    check("negsat_final", y, 16'h8000);

    // Random coefficients and samples
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) begin
        for (int k = 0; k < TAPS; k++) begin
          r = (i % 8 == 0) ? 16'($urandom) : 16'($signed(10'($urandom)));
          write_coef(3'(k), r);
        end
      end
      xa = (i % 2 == 0) ? 16'($urandom) : 16'($signed(11'($urandom)));
      run_sample(xa, 1'b0, 3'd0, 16'h0, 1'b0, y, lat);
      check($sformatf("random_%0d", i), y, filt_ref());
    end

    // Backpressure in HOLD
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    xb = 16'($urandom);
    in_valid = 1'b1; in_sample = xb;
    tick();
    model_push(to_int(xb));
    in_sample = 16'h1234;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("bp_out_valid_wait", out_valid, 1);
    yb = out_sample;
    check("bp_result", yb, filt_ref());
    repeat (5) begin
      tick();
      check("bp_stable", out_sample, yb);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    run_sample(16'($urandom), 1'b0, 3'd0, 16'h0, 1'b0, y, lat);
    check("bp_line_untouched", y, filt_ref());

    // Coefficient writes while busy are ignored; in idle they take effect
    write_coef(3'd0, 16'h0100);
    run_sample(16'h0100, 1'b0, 3'd0, 16'h0, 1'b1, y, lat);
    check("busywr_current", y, filt_ref());
    run_sample(16'h0100, 1'b0, 3'd0, 16'h0, 1'b1, y, lat);
    check("busywr_next", y, filt_ref());
    write_coef(3'd0, 16'h0200);
    run_sample(16'h0100, 1'b0, 3'd0, 16'h0, 1'b0, y, lat);
    check("idlewr_next", y, filt_ref());

    // Coefficient write and transfer in the same cycle
    run_sample(16'h0180, 1'b1, 3'd0, 16'hFE40, 1'b0, y, lat);
    check("samecycle_wr", y, filt_ref());
    run_sample(16'h0300, 1'b1, 3'd5, 16'h0077, 1'b0, y, lat);
    check("samecycle_wr2", y, filt_ref());

    // Throughput with out_ready held high
    xa = 16'($urandom); xb = 16'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    cnt = 0; t0 = -1; t1 = -1;
    for (int c = 0; c < 60 && cnt < 2; c++) begin
      in_sample = (cnt == 0) ? xa : xb;
      if (in_ready) begin
        if (cnt == 0) t0 = c; else t1 = c;
        model_push(to_int(in_sample));
        cnt++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("thru_transfers", cnt, 2);
    check("thru_period", t1 - t0, TAPS + 2);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("thru_out_valid_wait", out_valid, 1);
    check("thru_result", out_sample, filt_ref());
    tick();
    out_ready = 1'b0;
    check("thru_idle", in_ready, 1);

    // Reset in the middle of MAC
    for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'h0100);
    in_valid = 1'b1; in_sample = 16'h0100;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("midmac_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_sample", out_sample, 16'h0000);
    check("midrst_in_ready", in_ready, 1);
    repeat (3) begin
      tick();
      check("midrst_no_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    model_reset();
    check("midrst_rel_in_ready", in_ready, 1);
    run_sample(16'h0100, 1'b0, 3'd0, 16'h0, 1'b0, y, lat);
    check("midrst_zero_coef", y, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
